flag_branch_unit: RTL and testbench

- Sits directly downstream of the 16-bit saturating adder in EX.
- Captures its N/Z/V outputs into the architectural flag register under a per-instruction write mask.
- Evaluates 3-bit branch condition codes against those flags, with a small FSM that stalls a branch for one cycle when a flag-setting instruction is still in flight.
- Optional combinational bypass removes that stall.

---
 rtl/flag_branch_unit_if.sv | 30 +++
 rtl/flag_branch_unit.sv | 95 +++++++++
 tb/tb_flag_branch_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/flag_branch_unit_if.sv
// EX flag source and branch request/response bundle for flag_branch_unit.
// Latency: n/a (wiring only).
// Backpressure: br_stall is the only hold-back signal; stall/flush come from the pipeline.
interface flag_branch_unit_if;
  logic       ex_valid;
  logic [2:0] ex_flag_we;
  logic       alu_N;
  logic       alu_Z;
  logic       alu_V;
  logic       stall;
  logic       flush;
  logic       br_req;
  logic [2:0] br_ccc;
  logic       br_stall;
  logic       br_resolved;
  logic       br_taken;
  logic       flag_N;
  logic       flag_Z;
  logic       flag_V;

  modport master (
    output ex_valid, ex_flag_we, alu_N, alu_Z, alu_V, stall, flush, br_req, br_ccc,
    input  br_stall, br_resolved, br_taken, flag_N, flag_Z, flag_V
  );

  modport slave (
    input  ex_valid, ex_flag_we, alu_N, alu_Z, alu_V, stall, flush, br_req, br_ccc,
    output br_stall, br_resolved, br_taken, flag_N, flag_Z, flag_V
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural N/Z/V flag register plus branch condition evaluator with a one-cycle hazard wait.
// Latency: flags update on the clock edge; branch outcome is same-cycle, or one cycle later on a hazard (BYPASS=0).
// Backpressure: br_stall holds a branch while a flag writer is in EX; global stall freezes everything, flush wins over stall.
module flag_branch_unit #(
  parameter bit BYPASS = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  flag_branch_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t     state;
  logic [2:0] flags;     // {N, Z, V}
  logic [2:0] alu_nzv;
  logic [2:0] merged;    // alu values over registered flags under the write mask
  logic [2:0] eff;
  logic       hazard;
  logic       flag_upd;
  logic       o_stall;
  logic       o_resolved;
  logic       o_taken;

  assign alu_nzv  = {bus.alu_N, bus.alu_Z, bus.alu_V};
  assign merged   = (alu_nzv & bus.ex_flag_we) | (flags & ~bus.ex_flag_we);
  assign hazard   = bus.ex_valid & (|bus.ex_flag_we) & ~bus.flush;
  assign flag_upd = bus.ex_valid & ~bus.stall & ~bus.flush;
  // With bypass the in-flight writer's flags are visible immediately, so no hazard wait is needed.
  assign eff      = (BYPASS && hazard) ? merged : flags;

  function automatic logic cond_true(input logic [2:0] ccc, input logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (ccc)
      3'b000:  cond_true = ~z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = ~z & ~n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = ~n | z;
      3'b101:  cond_true = n | z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  // Flag register and branch FSM; flush beats stall, stall freezes everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
      state <= IDLE;
    end else begin
      if (flag_upd) begin
        flags <= merged;
      end
      if (bus.flush) begin
        state <= IDLE;
      end else if (!bus.stall) begin
        case (state)
          IDLE:    if (bus.br_req && !BYPASS && hazard) state <= WAIT;
          default: state <= IDLE;  // WAIT lasts one unstalled cycle, resolve or abort
        endcase
      end
    end
  end

  // Branch outputs are same-cycle so a hazard-free branch resolves without a bubble.
  always_comb begin
    o_stall    = 1'b0;
    o_resolved = 1'b0;
    o_taken    = 1'b0;
    if (rst_n && !bus.flush && !bus.stall && bus.br_req) begin
      if (state == WAIT) begin
        // The flag writer has retired into the register; a new writer in EX is behind this branch.
        o_resolved = 1'b1;
        o_taken    = cond_true(bus.br_ccc, flags);
      end else if (!BYPASS && hazard) begin
        o_stall = 1'b1;
      end else begin
        o_resolved = 1'b1;
        o_taken    = cond_true(bus.br_ccc, eff);
      end
    end
  end

  assign bus.br_stall    = o_stall;
  assign bus.br_resolved = o_resolved;
  assign bus.br_taken    = o_taken;
  assign bus.flag_N      = flags[2];
  assign bus.flag_Z      = flags[1];
  assign bus.flag_V      = flags[0];

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: one instance without bypass, one with, driven identically.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A rule-level reference model (flag bits, one waiting-branch bit) supplies every expectation.
module tb_flag_branch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ex_valid;
  logic [2:0] ex_flag_we;
  logic [2:0] alu_nzv;
  logic       stall;
  logic       flush;
  logic       br_req;
  logic [2:0] br_ccc;

  flag_branch_unit_if if0 ();
  flag_branch_unit_if if1 ();

  assign if0.ex_valid   = ex_valid;
  assign if0.ex_flag_we = ex_flag_we;
  assign if0.alu_N      = alu_nzv[2];
  assign if0.alu_Z      = alu_nzv[1];
  assign if0.alu_V      = alu_nzv[0];
  assign if0.stall      = stall;
  assign if0.flush      = flush;
  assign if0.br_req     = br_req;
  assign if0.br_ccc     = br_ccc;
  assign if1.ex_valid   = ex_valid;
  assign if1.ex_flag_we = ex_flag_we;
  assign if1.alu_N      = alu_nzv[2];
  assign if1.alu_Z      = alu_nzv[1];
  assign if1.alu_V      = alu_nzv[0];
  assign if1.stall      = stall;
  assign if1.flush      = flush;
  assign if1.br_req     = br_req;
  assign if1.br_ccc     = br_ccc;

  flag_branch_unit #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  flag_branch_unit #(.BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int checks = 0;
  int passed = 0;

  // Reference state: architectural flags {N,Z,V} and "a branch is parked waiting" (non-bypass unit only).
  logic [2:0] m_flags;
  bit         m_wait;

  function automatic bit cond_ref(input logic [2:0] ccc, input logic [2:0] f);
    bit n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n || z;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  function automatic logic [2:0] outs(input int bp);
    if (bp == 0) return {if0.br_stall, if0.br_resolved, if0.br_taken};
    return {if1.br_stall, if1.br_resolved, if1.br_taken};
  endfunction

  function automatic logic [2:0] flg(input int bp);
    if (bp == 0) return {if0.flag_N, if0.flag_Z, if0.flag_V};
    return {if1.flag_N, if1.flag_Z, if1.flag_V};
  endfunction

  // One clock cycle: drive, check at the falling edge against the model, advance the model at the rising edge.
  task automatic step(input bit ev, input logic [2:0] we, input logic [2:0] nzv,
                      input bit st, input bit fl, input bit rq, input logic [2:0] ccc);
    bit         hz;
    logic [2:0] eff;
    logic [2:0] exp_o;
    ex_valid = ev; ex_flag_we = we; alu_nzv = nzv;
    stall = st; flush = fl; br_req = rq; br_ccc = ccc;
    hz = ev && (we != 3'b000) && !fl;
    @(negedge clk);
    for (int bp = 0; bp < 2; bp++) begin
      exp_o = 3'b000;  // {stall, resolved, taken}
      if (!st && !fl && rq) begin
        if (bp == 0 && m_wait) begin
          exp_o = {1'b0, 1'b1, cond_ref(ccc, m_flags)};
        end else if (bp == 0 && hz) begin
          exp_o = 3'b100;
        end else begin
          eff = m_flags;
          if (bp == 1 && hz)
            for (int b = 0; b < 3; b++) if (we[b]) eff[b] = nzv[b];
          exp_o = {1'b0, 1'b1, cond_ref(ccc, eff)};
        end
      end
      chk($sformatf("dut%0d br_out", bp), {1'b0, outs(bp)}, {1'b0, exp_o});
      chk($sformatf("dut%0d flags", bp), {1'b0, flg(bp)}, {1'b0, m_flags});
    end
    @(posedge clk);
    if (!fl && !st) begin
      if (ev) for (int b = 0; b < 3; b++) if (we[b]) m_flags[b] = nzv[b];
      m_wait = !m_wait && rq && hz;
    end else if (fl) begin
      m_wait = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_flag_we = 0; alu_nzv = 0; stall = 0; flush = 0; br_req = 0; br_ccc = 0;
  endtask

  initial begin
    m_flags = 3'b000;
    m_wait  = 1'b0;
    // Reset with a hazard branch presented: outputs must stay quiet, flags clear.
    rst_n = 1'b0;
    ex_valid = 1; ex_flag_we = 3'b111; alu_nzv = 3'b111; stall = 0; flush = 0; br_req = 1; br_ccc = 3'b111;
    #12;
    chk("reset dut0 br_out", {1'b0, outs(0)}, 4'b0000);
    chk("reset dut1 br_out", {1'b0, outs(1)}, 4'b0000);
    chk("reset dut0 flags", {1'b0, flg(0)}, 4'b0000);
    chk("reset dut1 flags", {1'b0, flg(1)}, 4'b0000);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // EQ on cleared flags resolves not-taken.
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b001);
    // Full-mask write Z=1, then EQ taken and NE not taken.
    step(1, 3'b111, 3'b010, 0, 0, 0, 3'b000);
    chk("z set", {3'b000, if0.flag_Z}, 4'b0001);
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b001);
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b000);
    // Masked update: only Z written.
    step(1, 3'b111, 3'b111, 0, 0, 0, 3'b000);
    step(1, 3'b010, 3'b000, 0, 0, 0, 3'b000);
    chk("masked update", {1'b0, flg(0)}, 4'b0101);
    // Mask 000 never writes.
    step(1, 3'b000, 3'b010, 0, 0, 0, 3'b000);
    chk("zero mask", {1'b0, flg(1)}, 4'b0101);
    // LT with a flag writer (N=1) in EX: unit 0 stalls then resolves, unit 1 resolves at once.
    step(1, 3'b111, 3'b100, 0, 0, 1, 3'b011);
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b011);
    // Hazard held under global stall for three cycles.
    for (int i = 0; i < 3; i++) step(1, 3'b111, 3'b010, 1, 0, 1, 3'b000);
    chk("stall froze flags", {1'b0, flg(0)}, 4'b0100);
    // Enter WAIT, flush it, then OV on V=1.
    step(1, 3'b111, 3'b001, 0, 0, 1, 3'b110);
    step(1, 3'b111, 3'b000, 0, 1, 1, 3'b110);
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b110);
    // UNCOND on flags 000.
    step(1, 3'b111, 3'b000, 0, 0, 0, 3'b000);
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b111);
    // Stall while waiting holds WAIT; release resolves on updated flags; new hazard in WAIT ignored.
    step(1, 3'b101, 3'b100, 0, 0, 1, 3'b101);
    step(1, 3'b111, 3'b000, 1, 0, 1, 3'b101);
    step(1, 3'b111, 3'b000, 1, 0, 1, 3'b101);
    step(1, 3'b111, 3'b010, 0, 0, 1, 3'b101);
    // WAIT with br_req dropped aborts.
    step(1, 3'b111, 3'b100, 0, 0, 1, 3'b011);
    step(0, 3'b000, 3'b000, 0, 0, 0, 3'b011);
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b011);
    // Reset while waiting: immediate quiet outputs, flags clear.
    step(1, 3'b111, 3'b101, 0, 0, 1, 3'b110);
    ex_valid = 0; ex_flag_we = 0; br_req = 1; br_ccc = 3'b110;
    rst_n = 1'b0;
    #1;
    chk("midwait reset br_out", {1'b0, outs(0)}, 4'b0000);
    chk("midwait reset flags", {1'b0, flg(0)}, 4'b0000);
    m_flags = 3'b000;
    m_wait  = 1'b0;
    #2;
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b001);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
